pb_timer: RTL and testbench



---
 rtl/pb_timer_pkg.sv | 35 +++
 rtl/pb_timer_prescaler.sv | 44 ++++
 rtl/pb_timer.sv | 171 +++++++++++++++++
 tb/tb_pb_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_timer_pkg.sv
// ---------------------------------------------------------------------------
// pb_timer_pkg
// Shared definitions for the Picoblaze port-mapped timer:
//   - register offsets inside the 7-entry port window
//   - CTRL / STATUS bit positions
//   - small helper for building the CTRL read-back byte
// ---------------------------------------------------------------------------
package pb_timer_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [2:0] TMR_CTRL      = 3'd0;
    localparam logic [2:0] TMR_PRESCALE  = 3'd1;
    localparam logic [2:0] TMR_RELOAD_LO = 3'd2;
    localparam logic [2:0] TMR_RELOAD_HI = 3'd3;
    localparam logic [2:0] TMR_COUNT_LO  = 3'd4;
    localparam logic [2:0] TMR_COUNT_HI  = 3'd5;
    localparam logic [2:0] TMR_STATUS    = 3'd6;

    // Number of decoded registers in the window
    localparam logic [7:0] TMR_NUM_REGS  = 8'd7;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // STATUS bit index
    localparam int STATUS_EXP = 0;

    // CTRL occupies the low three bits; the rest read as zero.
    function automatic logic [7:0] ctrl_readback(input logic [2:0] ctrl);
        return {5'b0_0000, ctrl};
    endfunction

endpackage

// File: rtl/pb_timer_prescaler.sv
// ---------------------------------------------------------------------------
// pb_timer_prescaler
// 8-bit free-running divider. While en is high the count advances every
// cycle; when it equals limit, tick is asserted for that cycle and the count
// wraps to zero on the following edge. en low freezes the count.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   en     in   count enable (timer EN bit)
//   clr    in   force count to zero (timer start)
//   limit  in   8-bit terminal value (PRESCALE register)
//   tick   out  terminal-count strobe, combinational from the count register
// ---------------------------------------------------------------------------
module pb_timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       tick
);

    logic [7:0] count_r;

    // The tick must be visible in the same cycle the count matches, so the
    // down-counter can act on the very edge that wraps the prescaler.
    assign tick = en && (count_r == limit);

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (tick) begin
            count_r <= 8'd0;
        end else if (en) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pb_timer.sv
// ---------------------------------------------------------------------------
// pb_timer
// Port-mapped 16-bit down-counting timer with interrupt for the Picoblaze.
// Registers live at BASE_ADDR+0 .. BASE_ADDR+6 (see pb_timer_pkg offsets).
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   port_id        in   CPU port address
//   out_port       in   CPU write data
//   write_strobe   in   one-cycle write qualifier
//   read_strobe    in   one-cycle read qualifier (used for the HI shadow)
//   interrupt_ack  in   one-cycle acknowledge, clears EXP
//   in_port        out  registered read data, follows port_id every cycle
//   interrupt      out  EXP & IE
// ---------------------------------------------------------------------------
module pb_timer
    import pb_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port,
    output logic       interrupt
);

    // Architectural state
    logic [2:0]  ctrl_r;
    logic [7:0]  prescale_r;
    logic [15:0] reload_r;
    logic [15:0] count_r;
    logic [7:0]  shadow_r;
    logic        exp_r;

    // Decode
    logic [7:0]  offset_s;
    logic        hit_s;
    logic [2:0]  sel_s;
    logic        wr_ctrl_s;
    logic        wr_status_s;
    logic        start_s;
    logic        tick_s;

    // Next-state
    logic [15:0] count_tick_s;
    logic        en_tick_s;
    logic        exp_set_s;
    logic        exp_clr_s;
    logic [2:0]  ctrl_next_s;
    logic [15:0] count_next_s;
    logic        exp_next_s;
    logic [7:0]  rd_data_s;

    // Subtraction wraps for port_id below BASE_ADDR, so a single unsigned
    // compare covers both ends of the window.
    assign offset_s    = port_id - BASE_ADDR;
    assign hit_s       = (offset_s < TMR_NUM_REGS);
    assign sel_s       = offset_s[2:0];
    assign wr_ctrl_s   = write_strobe && hit_s && (sel_s == TMR_CTRL);
    assign wr_status_s = write_strobe && hit_s && (sel_s == TMR_STATUS);
    // Only a 0->1 transition of EN restarts the timer.
    assign start_s     = wr_ctrl_s && out_port[CTRL_EN] && !ctrl_r[CTRL_EN];
    assign exp_clr_s   = interrupt_ack || (wr_status_s && out_port[STATUS_EXP]);
    // A set in the same cycle as a clear leaves EXP high.
    assign exp_next_s  = exp_set_s || (exp_r && !exp_clr_s);
    assign interrupt   = exp_r && ctrl_r[CTRL_IE];

    pb_timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_r[CTRL_EN]),
        .clr   (start_s),
        .limit (prescale_r),
        .tick  (tick_s)
    );

    // Effect of a prescaler tick on COUNT, EN and EXP, before any CPU write
    always_comb begin
        count_tick_s = count_r;
        en_tick_s    = ctrl_r[CTRL_EN];
        exp_set_s    = 1'b0;
        if (tick_s) begin
            if (count_r != 16'd0) begin
                count_tick_s = count_r - 16'd1;
            end else begin
                exp_set_s = 1'b1;
                if (ctrl_r[CTRL_AUTO]) begin
                    count_tick_s = reload_r;
                end else begin
                    en_tick_s = 1'b0;
                end
            end
        end else begin
            count_tick_s = count_r;
        end
    end

    // CTRL write overrides the tick: start reloads, EN=0 freezes COUNT
    always_comb begin
        ctrl_next_s  = {ctrl_r[CTRL_IE], ctrl_r[CTRL_AUTO], en_tick_s};
        count_next_s = count_tick_s;
        if (wr_ctrl_s) begin
            ctrl_next_s = out_port[2:0];
            if (start_s) begin
                count_next_s = reload_r;
            end else if (out_port[CTRL_EN]) begin
                count_next_s = count_tick_s;
            end else begin
                count_next_s = count_r;
            end
        end else begin
            ctrl_next_s = {ctrl_r[CTRL_IE], ctrl_r[CTRL_AUTO], en_tick_s};
        end
    end

    // Read mux from current register state; COUNT_HI always comes from the shadow
    always_comb begin
        rd_data_s = 8'h00;
        if (hit_s) begin
            case (sel_s)
                TMR_CTRL:      rd_data_s = ctrl_readback(ctrl_r);
                TMR_PRESCALE:  rd_data_s = prescale_r;
                TMR_RELOAD_LO: rd_data_s = reload_r[7:0];
                TMR_RELOAD_HI: rd_data_s = reload_r[15:8];
                TMR_COUNT_LO:  rd_data_s = count_r[7:0];
                TMR_COUNT_HI:  rd_data_s = shadow_r;
                TMR_STATUS:    rd_data_s = {7'b000_0000, exp_r};
                default:       rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Register file, down-counter, shadow and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= 3'd0;
            prescale_r <= 8'd0;
            reload_r   <= 16'd0;
            count_r    <= 16'd0;
            shadow_r   <= 8'd0;
            exp_r      <= 1'b0;
            in_port    <= 8'd0;
        end else begin
            ctrl_r  <= ctrl_next_s;
            count_r <= count_next_s;
            exp_r   <= exp_next_s;
            in_port <= rd_data_s;
            if (write_strobe && hit_s && (sel_s == TMR_PRESCALE)) begin
                prescale_r <= out_port;
            end
            if (write_strobe && hit_s && (sel_s == TMR_RELOAD_LO)) begin
                reload_r[7:0] <= out_port;
            end
            if (write_strobe && hit_s && (sel_s == TMR_RELOAD_HI)) begin
                reload_r[15:8] <= out_port;
            end
            // Freeze the high byte when the low byte is read
            if (read_strobe && hit_s && (sel_s == TMR_COUNT_LO)) begin
                shadow_r <= count_r[15:8];
            end
        end
    end

endmodule

// File: tb/tb_pb_timer.sv
// ---------------------------------------------------------------------------
// tb_pb_timer
// Directed bench for pb_timer. One instance at the default base (8'h10) and
// one at 8'h40 sharing the CPU bus, so the second sees the first's traffic
// as out-of-window accesses. Expected values are queued when a step is
// driven and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_pb_timer;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port_a;
    logic       interrupt_a;
    logic [7:0] in_port_b;
    logic       interrupt_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    pb_timer #(.BASE_ADDR(8'h10)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .interrupt_ack(interrupt_ack), .in_port(in_port_a), .interrupt(interrupt_a)
    );

    pb_timer #(.BASE_ADDR(8'h40)) dut40 (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .interrupt_ack(interrupt_ack), .in_port(in_port_b), .interrupt(interrupt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // All tasks are entered just after a falling edge and return just after one.

    task automatic compare(input string tag, input logic [7:0] got);
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s got %02h exp %02h", tag, got, e);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input string tag, input bit which, input logic [7:0] addr,
                      input logic [7:0] exp);
        port_id     = addr;
        read_strobe = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        compare(tag, which ? in_port_b : in_port_a);
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input bit which, input logic exp);
        exp_q.push_back({7'd0, exp});
        compare(tag, {7'd0, which ? interrupt_b : interrupt_a});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        idle(3);
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            rd("rst_reg", 1'b0, 8'h10 + 8'(i), 8'h00);
        end
        wr(8'h10, 8'hFF);
        rd("ctrl_rb", 1'b0, 8'h10, 8'h07);
        wr(8'h10, 8'h00);
        wr(8'h16, 8'h01);
        chk_irq("w1c_irq", 1'b0, 1'b0);
        rd("w1c_stat", 1'b0, 8'h16, 8'h00);

        // One-shot: PRESCALE=0, RELOAD=3, EXP at W+4
        wr(8'h11, 8'h00);
        wr(8'h12, 8'h03);
        wr(8'h13, 8'h00);
        wr(8'h10, 8'h05);
        idle(3);
        chk_irq("os_pre", 1'b0, 1'b0);
        idle(1);
        chk_irq("os_exp", 1'b0, 1'b1);
        rd("os_ctrl", 1'b0, 8'h10, 8'h04);
        rd("os_cntlo", 1'b0, 8'h14, 8'h00);
        rd("os_cnthi", 1'b0, 8'h15, 8'h00);
        rd("os_stat", 1'b0, 8'h16, 8'h01);
        ack_pulse();
        chk_irq("os_ack", 1'b0, 1'b0);

        // Auto-reload: PRESCALE=2, RELOAD=1, EXP at W+6, W+12, W+18
        wr(8'h11, 8'h02);
        wr(8'h12, 8'h01);
        wr(8'h10, 8'h07);
        for (int k = 0; k < 3; k++) begin
            idle(k == 0 ? 5 : 4);
            chk_irq("ar_pre", 1'b0, 1'b0);
            idle(1);
            chk_irq("ar_exp", 1'b0, 1'b1);
            ack_pulse();
            chk_irq("ar_ack", 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            rd("ar_cnt", 1'b0, 8'h14, (k % 2 == 0) ? 8'h01 : 8'h00);
            idle(2);
        end
        wr(8'h10, 8'h00);
        wr(8'h16, 8'h01);
        chk_irq("ar_stop", 1'b0, 1'b0);

        // Coherent read: RELOAD=0x0100, PRESCALE=0
        wr(8'h11, 8'h00);
        wr(8'h12, 8'h00);
        wr(8'h13, 8'h01);
        wr(8'h10, 8'h01);
        rd("coh_lo", 1'b0, 8'h14, 8'h00);
        idle(2);
        rd("coh_hi", 1'b0, 8'h15, 8'h01);
        wr(8'h10, 8'h00);

        // Collision: ack and W1C in the expiry cycle (W+3)
        wr(8'h12, 8'h02);
        wr(8'h13, 8'h00);
        wr(8'h10, 8'h05);
        idle(2);
        port_id = 8'h16; out_port = 8'h01; write_strobe = 1'b1; interrupt_ack = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; interrupt_ack = 1'b0;
        chk_irq("col_irq", 1'b0, 1'b1);
        rd("col_stat", 1'b0, 8'h16, 8'h01);
        ack_pulse();
        chk_irq("col_clr", 1'b0, 1'b0);

        // EN rewrite does not reload; CTRL=0 in a tick cycle freezes COUNT
        wr(8'h12, 8'h10);
        wr(8'h10, 8'h01);
        idle(2);
        wr(8'h10, 8'h01);
        wr(8'h10, 8'h00);
        rd("col_cnt", 1'b0, 8'h14, 8'h0D);
        idle(3);
        rd("frozen", 1'b0, 8'h14, 8'h0D);

        // Reset mid-count
        wr(8'h12, 8'h05);
        wr(8'h10, 8'h07);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk_irq("mr_irq", 1'b0, 1'b0);
        rd("mr_ctrl", 1'b0, 8'h10, 8'h00);
        rd("mr_cnt", 1'b0, 8'h14, 8'h00);
        rd("mr_rel", 1'b0, 8'h12, 8'h00);

        // Address decode on the 8'h40 instance
        wr(8'h10, 8'h07);
        wr(8'h11, 8'h33);
        wr(8'h47, 8'hFF);
        wr(8'h10, 8'h00);
        for (int i = 0; i < 7; i++) begin
            rd("dec_reg", 1'b1, 8'h40 + 8'(i), 8'h00);
        end
        rd("dec_47", 1'b1, 8'h47, 8'h00);
        rd("dec_pre_a", 1'b0, 8'h11, 8'h33);
        rd("dec_17", 1'b0, 8'h17, 8'h00);
        chk_irq("dec_irq", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
